// File: rtl/ledgame_pkg.sv
// Shared constants for the LED game: game-state encodings and the
// active-low 7-segment patterns ({g,f,e,d,c,b,a}, 0 = segment lit).
package ledgame_pkg;

  // Game states, kept as plain 2-bit constants so legacy blocks can share them.
  localparam logic [1:0] S0_IDLE  = 2'd0;
  localparam logic [1:0] S1_RUN   = 2'd1;
  localparam logic [1:0] S2_END   = 2'd2;
  localparam logic [1:0] S3_PAUSE = 2'd3;

  // Digit patterns 0..9, index 0 in the least significant slot.
  localparam logic [9:0][6:0] SEG_DIGIT = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_encode.sv
// Combinational nibble-to-segment encoder; non-BCD nibbles show 'E'.
module seg7_encode
  import ledgame_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  // Map a BCD nibble to its pattern, anything above 9 becomes 'E'.
  always_comb begin
    // NOTE: assign a default first so every path drives o_seg and no latch is inferred.
    o_seg = SEG_E;
    if (i_nibble < 4'd10) o_seg = SEG_DIGIT[i_nibble];
  end

endmodule

// File: rtl/score_display.sv
// Four-digit multiplexed score display with leading-zero blanking,
// a per-slot anti-ghosting guard cycle, and blinking in END GAME.
module score_display
  import ledgame_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_SCANS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] POINT,
  input  logic [1:0]  STATE,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int DW = $clog2(REFRESH_DIV);
  localparam int SW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(BLINK_SCANS - 1);

  logic [DW-1:0] r_dwell;
  logic [1:0]    r_digit;
  logic [15:0]   r_shadow;
  logic [SW-1:0] r_scan_cnt;
  logic          r_blink_vis;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;

  logic          w_term;
  logic          w_scan_done;
  logic          w_guard;
  logic [3:0]    w_nibble;
  logic          w_blank;
  logic [6:0]    w_digit_seg;
  logic [6:0]    w_score_seg;
  logic [3:0]    w_an_nxt;
  logic [6:0]    w_seg_nxt;
  logic          w_dp_nxt;

  assign w_term      = (r_dwell == DWELL_LAST);
  assign w_scan_done = w_term && (r_digit == 2'd3);
  assign w_guard     = (r_dwell == '0);

  // Select the shadow nibble for the current slot and decide leading-zero blanking.
  always_comb begin
    w_nibble = r_shadow[3:0];
    w_blank  = 1'b0;
    case (r_digit)
      2'd0: w_nibble = r_shadow[3:0];
      2'd1: begin
        w_nibble = r_shadow[7:4];
        w_blank  = (r_shadow[15:4] == 12'h000);
      end
      2'd2: begin
        w_nibble = r_shadow[11:8];
        w_blank  = (r_shadow[15:8] == 8'h00);
      end
      default: begin
        w_nibble = r_shadow[15:12];
        w_blank  = (r_shadow[15:12] == 4'h0);
      end
    endcase
  end

  seg7_encode u_enc (
    .i_nibble (w_nibble),
    .o_seg    (w_digit_seg)
  );

  assign w_score_seg = w_blank ? SEG_BLANK : w_digit_seg;

  // Next output values from this cycle's scan position, shadow and game state.
  always_comb begin
    w_an_nxt  = w_guard ? 4'hF : ~(4'b0001 << r_digit);
    w_seg_nxt = w_score_seg;
    w_dp_nxt  = 1'b1;
    case (STATE)
      S0_IDLE:  w_seg_nxt = SEG_DASH;
      S1_RUN:   w_seg_nxt = w_score_seg;
      S2_END:   w_seg_nxt = r_blink_vis ? w_score_seg : SEG_BLANK;
      default:  w_dp_nxt  = (r_digit != 2'd0);
    endcase
  end

  // Dwell counter and digit index; the digit advances at each terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dwell <= '0;
      r_digit <= 2'd0;
    end else if (w_term) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_dwell <= '0;
      r_digit <= r_digit + 2'd1;
    end else begin
      r_dwell <= r_dwell + 1'b1;
    end
  end

  // Capture the score once per scan, in the digit-0 guard cycle, so a scan never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        r_shadow <= 16'h0000;
    else if (w_guard && r_digit == 2'd0) r_shadow <= POINT;
  end

  // Blink phase in END GAME: toggle after BLINK_SCANS full scans; forced visible elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt  <= '0;
      r_blink_vis <= 1'b1;
    end else if (STATE != S2_END) begin
      r_scan_cnt  <= '0;
      r_blink_vis <= 1'b1;
    end else if (w_scan_done) begin
      if (r_scan_cnt == SCAN_LAST) begin
        r_scan_cnt  <= '0;
        r_blink_vis <= ~r_blink_vis;
      end else begin
        r_scan_cnt <= r_scan_cnt + 1'b1;
      end
    end
  end

  // Register anodes, segments and dp together so a lit anode never sees a stale pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= 4'hF;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
      r_dp  <= w_dp_nxt;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display with a short dwell and blink period.
module tb_score_display;

  localparam int DIV = 4;
  localparam int BS  = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] point = 16'h0000;
  logic [1:0]  state = 2'd0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_checks = 0;
  int n_pass   = 0;

  score_display #(.REFRESH_DIV(DIV), .BLINK_SCANS(BS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .POINT (point),
    .STATE (state),
    .an    (an),
    .seg   (seg),
    .dp    (dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, act, exp);
  endtask

  // One clock of a slot: guard cycles only check that all anodes are off.
  task automatic cyc(input string tag, input int digit, input bit guard,
                     input logic [6:0] s, input logic d);
    logic [3:0] e_an;
    @(posedge clk); #1;
    if (guard) begin
      check({tag, " guard an"}, 16'(an), 16'h000F);
    end else begin
      e_an = ~(4'b0001 << digit);
      check({tag, " an"},  16'(an),  16'(e_an));
      check({tag, " seg"}, 16'(seg), 16'(s));
      check({tag, " dp"},  16'(dp),  16'(d));
    end
  endtask

  task automatic slot(input string tag, input int digit, input logic [6:0] s, input logic d);
    cyc(tag, digit, 1'b1, s, d);
    repeat (DIV - 1) cyc(tag, digit, 1'b0, s, d);
  endtask

  task automatic scan(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                      input logic [6:0] s2, input logic [6:0] s3, input logic dp0);
    slot({tag, " d0"}, 0, s0, dp0);
    slot({tag, " d1"}, 1, s1, 1'b1);
    slot({tag, " d2"}, 2, s2, 1'b1);
    slot({tag, " d3"}, 3, s3, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    // Reset held: outputs at their idle values.
    repeat (3) @(posedge clk);
    #1;
    check("rst an",  16'(an),  16'h000F);
    check("rst seg", 16'(seg), 16'h007F);
    check("rst dp",  16'(dp),  16'h0001);
    @(negedge clk) rst_n = 1'b1;

    // IDLE: dashes everywhere regardless of the score.
    state = 2'd0; point = 16'h1234;
    scan("idle", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b1);

    // RUN 42 with leading-zero blanking.
    state = 2'd1; point = 16'h0042;
    scan("run42", 7'h24, 7'h19, 7'h7F, 7'h7F, 1'b1);

    // Score changes mid-scan: the rest of this scan keeps 42.
    slot("tear d0", 0, 7'h24, 1'b1);
    cyc("tear d1", 1, 1'b1, 7'h19, 1'b1);
    cyc("tear d1", 1, 1'b0, 7'h19, 1'b1);
    point = 16'h0057;
    cyc("tear d1", 1, 1'b0, 7'h19, 1'b1);
    cyc("tear d1", 1, 1'b0, 7'h19, 1'b1);
    slot("tear d2", 2, 7'h7F, 1'b1);
    slot("tear d3", 3, 7'h7F, 1'b1);
    scan("run57", 7'h78, 7'h12, 7'h7F, 7'h7F, 1'b1);

    // Non-BCD tens nibble shows E and counts as non-zero.
    point = 16'h00A3;
    scan("runA3", 7'h30, 7'h06, 7'h7F, 7'h7F, 1'b1);

    // Inner zeros below a non-zero top digit are shown.
    point = 16'h1000;
    scan("run1000", 7'h40, 7'h40, 7'h40, 7'h79, 1'b1);

    // END GAME blink: 2 scans visible, 2 hidden, 2 visible, then hidden again.
    state = 2'd2; point = 16'h0105;
    scan("end vis1", 7'h12, 7'h40, 7'h79, 7'h7F, 1'b1);
    scan("end vis2", 7'h12, 7'h40, 7'h79, 7'h7F, 1'b1);
    scan("end hid1", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 1'b1);
    scan("end hid2", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 1'b1);
    scan("end vis3", 7'h12, 7'h40, 7'h79, 7'h7F, 1'b1);
    scan("end vis4", 7'h12, 7'h40, 7'h79, 7'h7F, 1'b1);
    slot("end hid3 d0", 0, 7'h7F, 1'b1);
    slot("end hid3 d1", 1, 7'h7F, 1'b1);
    cyc("end hid3 d2", 2, 1'b1, 7'h7F, 1'b1);
    cyc("end hid3 d2", 2, 1'b0, 7'h7F, 1'b1);

    // PAUSE mid-hidden: visible on the very next cycle.
    state = 2'd3;
    cyc("pause d2", 2, 1'b0, 7'h79, 1'b1);
    cyc("pause d2", 2, 1'b0, 7'h79, 1'b1);
    slot("pause d3", 3, 7'h7F, 1'b1);
    scan("pause", 7'h12, 7'h40, 7'h79, 7'h7F, 1'b0);

    // Reset in the middle of a scan.
    state = 2'd1; point = 16'h0008;
    slot("pre-rst d0", 0, 7'h00, 1'b1);
    cyc("pre-rst d1", 1, 1'b1, 7'h7F, 1'b1);
    cyc("pre-rst d1", 1, 1'b0, 7'h7F, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst an",  16'(an),  16'h000F);
    check("midrst seg", 16'(seg), 16'h007F);
    check("midrst dp",  16'(dp),  16'h0001);
    point = 16'h0003;
    @(negedge clk) rst_n = 1'b1;
    scan("post-rst", 7'h30, 7'h7F, 7'h7F, 7'h7F, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
